// File: rtl/random_word_harvester_pkg.sv
// Shared constants and types for the random word harvester.
//
// Contents:
//   DEF_WIDTH / DEF_REP_CUTOFF  default word width and repetition cutoff
//   SYNC_STAGES                 depth of the metastable-bit synchronizer
//   WARMUP_CYCLES               cycles after reset release during which raw
//                               samples are ignored (covers synchronizer fill)
//   pair_phase_e                von Neumann pair position
//   out_state_e                 output register / health state
package random_word_harvester_pkg;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_REP_CUTOFF = 16;
  localparam int SYNC_STAGES    = 2;
  localparam int WARMUP_CYCLES  = 2;

  // Width of the repetition counter; large enough for any cutoff up to 255.
  localparam int REP_W = 8;

  typedef enum logic {
    PH_FIRST  = 1'b0,
    PH_SECOND = 1'b1
  } pair_phase_e;

  // S_EMPTY: no word presented, S_FULL: unconsumed word on out_data,
  // S_FAIL: health test tripped, stream permanently stopped until reset.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL  = 2'd1,
    S_FAIL  = 2'd2
  } out_state_e;

endpackage

// File: rtl/random_word_harvester_debiaser.sv
// von_neumann_debiaser: pairs successive raw samples and emits one unbiased
// bit per unequal pair (01 -> 0, 10 -> 1, i.e. the first bit of the pair);
// equal pairs are dropped.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous, active-low reset
//   raw        in   synchronized raw bit
//   enable     in   1 = pair samples; 0 = restart pairing at the first bit
//   raw_ok     in   raw is meaningful this cycle (post warm-up)
//   bit_valid  out  a debiased bit is presented this cycle
//   bit_out    out  the debiased bit (valid only with bit_valid)
//
// bit_valid/bit_out are combinational from the current raw sample so the
// packer registers the bit on the same edge the second sample arrives.
module von_neumann_debiaser
  import random_word_harvester_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic enable,
  input  logic raw_ok,
  output logic bit_valid,
  output logic bit_out
);

  pair_phase_e phase_q, phase_d;
  logic        first_q, first_d;

  always_comb begin
    phase_d   = phase_q;
    first_d   = first_q;
    bit_valid = 1'b0;
    bit_out   = first_q;
    if (!enable) begin
      phase_d = PH_FIRST;
    end else if (raw_ok) begin
      case (phase_q)
        PH_FIRST: begin
          first_d = raw;
          phase_d = PH_SECOND;
        end
        PH_SECOND: begin
          phase_d   = PH_FIRST;
          bit_valid = (first_q != raw);
        end
        default: phase_d = PH_FIRST;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= PH_FIRST;
      first_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      first_q <= first_d;
    end
  end

endmodule

// File: rtl/random_word_harvester.sv
// random_word_harvester: turns a raw metastable-oscillator bit into a stream
// of whitened WIDTH-bit random words, with a repetition-count health test.
//
// Flow: metastable -> 2-flop synchronizer -> warm-up gate -> von Neumann
// debiaser -> MSB-first packer -> XOR with lfsr_in on load -> valid/ready
// output register. The repetition counter watches the synchronized raw bit
// independently of enable and latches a sticky failure.
//
// Parameters:
//   WIDTH       word width (must match the LFSR stage), >= 2
//   REP_CUTOFF  consecutive identical raw bits that trip health_fail, 2..255
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous, active-low reset
//   metastable   in   raw oscillator bit, asynchronous to clk
//   lfsr_in      in   LFSR word, sampled only when a word is loaded
//   enable       in   1 = harvest; 0 = hold packer, restart pairing
//   out_data     out  whitened word
//   out_valid    out  out_data holds an unconsumed word
//   out_ready    in   consumer accepts when out_valid & out_ready
//   health_fail  out  sticky repetition-test failure
module random_word_harvester
  import random_word_harvester_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int REP_CUTOFF = DEF_REP_CUTOFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             metastable,
  input  logic [WIDTH-1:0] lfsr_in,
  input  logic             enable,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             health_fail
);

  localparam int CNT_W  = $clog2(WIDTH + 1);
  localparam int WARM_W = $clog2(WARMUP_CYCLES + 1);

  if (WIDTH < 2) begin : g_bad_width
    $error("random_word_harvester: WIDTH must be >= 2");
  end
  if (REP_CUTOFF < 2 || REP_CUTOFF > 255) begin : g_bad_cutoff
    $error("random_word_harvester: REP_CUTOFF must be in 2..255");
  end

  // Saturating increment for the repetition counter.
  function automatic logic [REP_W-1:0] rep_sat_inc(input logic [REP_W-1:0] v);
    if (v >= REP_W'(REP_CUTOFF)) return REP_W'(REP_CUTOFF);
    return v + REP_W'(1);
  endfunction

  // ---------------------------------------------------------------------
  // Synchronizer and warm-up gate
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic [WARM_W-1:0]      warm_q, warm_d;
  logic                   raw;
  logic                   raw_ok;

  assign raw    = sync_q[SYNC_STAGES-1];
  // The synchronizer still holds reset zeros for the first cycles after
  // release; those are not real samples and must not pair or count.
  assign raw_ok = (warm_q == WARM_W'(WARMUP_CYCLES));

  always_comb begin
    warm_d = warm_q;
    if (!raw_ok) warm_d = warm_q + WARM_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      warm_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], metastable};
      warm_q <= warm_d;
    end
  end

  // ---------------------------------------------------------------------
  // Repetition-count health test
  // ---------------------------------------------------------------------
  logic [REP_W-1:0] rep_q, rep_d;
  logic             prev_q, prev_d;
  logic             trip;

  always_comb begin
    rep_d  = rep_q;
    prev_d = prev_q;
    if (raw_ok) begin
      prev_d = raw;
      // rep_q == 0 only before the first counted sample: start a run.
      if (rep_q == '0 || raw != prev_q) rep_d = REP_W'(1);
      else                              rep_d = rep_sat_inc(rep_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_q  <= '0;
      prev_q <= 1'b0;
    end else begin
      rep_q  <= rep_d;
      prev_q <= prev_d;
    end
  end

  // ---------------------------------------------------------------------
  // Debiaser
  // ---------------------------------------------------------------------
  logic bit_valid;
  logic bit_out;

  von_neumann_debiaser u_debias (
    .clk       (clk),
    .rst       (rst),
    .raw       (raw),
    .enable    (enable),
    .raw_ok    (raw_ok),
    .bit_valid (bit_valid),
    .bit_out   (bit_out)
  );

  // ---------------------------------------------------------------------
  // Packer
  // ---------------------------------------------------------------------
  out_state_e       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             word_full;
  logic             load;

  assign word_full = (cnt_q == CNT_W'(WIDTH));
  // A full word moves to the output when the slot is free or is being
  // emptied on this same edge; never after the health test has failed.
  assign load = word_full &&
                ((state_q == S_EMPTY) || (state_q == S_FULL && out_ready));
  // Trip exactly once, on the edge the run length reaches the cutoff.
  assign trip = raw_ok && (rep_d == REP_W'(REP_CUTOFF)) && (state_q != S_FAIL);

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (trip || load) begin
      cnt_d = '0;
    end else if (bit_valid && !word_full) begin
      // First emitted bit ends up in the MSB after WIDTH shifts. Bits that
      // arrive while the word is full (stall or load edge) are dropped.
      shreg_d = {shreg_q[WIDTH-2:0], bit_out};
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Output register and health state
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: begin
        if (trip)      state_d = S_FAIL;
        else if (load) state_d = S_FULL;
      end
      S_FULL: begin
        if (trip)           state_d = S_FAIL;
        else if (load)      state_d = S_FULL;
        else if (out_ready) state_d = S_EMPTY;
      end
      S_FAIL:  state_d = S_FAIL;
      default: state_d = S_EMPTY;
    endcase
  end

  always_comb begin
    data_d = data_q;
    if (trip)      data_d = '0;
    else if (load) data_d = shreg_q ^ lfsr_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    out_valid   = (state_q == S_FULL);
    health_fail = (state_q == S_FAIL);
    out_data    = data_q;
  end

endmodule
